// File: rtl/sim_host_ctrl.sv
// sim_host_ctrl
//   Simulation host controller. It watches the core's store bus for two magic
//   addresses: a store to FINISH_ADDR ends the run (data kept as finish_code),
//   and a store to CONSOLE_ADDR queues st_wdata[7:0] in a small console FIFO.
//   A watchdog aborts the run when no instruction retires for WDOG_LIMIT
//   cycles. Run statistics (cycles, retired instructions, dropped console
//   bytes) are kept for the host.
//
//   State table
//     RUN   | normal execution; stores decoded, watchdog armed
//     DRAIN | finish requested; waiting for the console FIFO to empty
//     DONE  | run ended normally (terminal until rst)
//     ABORT | run ended by the watchdog (terminal until rst)
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   st_wen, st_addr, st_wdata     store bus snooped from the core
//   ret_valid[NUM_RET]            per-channel instruction-retired strobes
//   con_valid, con_data, con_ready  console byte stream (valid/ready)
//   finish, finish_code           normal end of run and its store data
//   wdog_abort                    run ended by watchdog
//   cycle_cnt, ret_cnt, con_drop  run statistics
module sim_host_ctrl #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   FINISH_ADDR  = 32'h1000_0000,
  parameter logic [XLEN-1:0]   CONSOLE_ADDR = 32'h0020_0000,
  parameter int                CON_DEPTH    = 8,
  parameter int                NUM_RET      = 2,
  parameter int                WDOG_LIMIT   = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_wen,
  input  logic [XLEN-1:0]    st_addr,
  input  logic [XLEN-1:0]    st_wdata,
  input  logic [NUM_RET-1:0] ret_valid,
  output logic               con_valid,
  output logic [7:0]         con_data,
  input  logic               con_ready,
  output logic               finish,
  output logic [XLEN-1:0]    finish_code,
  output logic               wdog_abort,
  output logic [63:0]        cycle_cnt,
  output logic [63:0]        ret_cnt,
  output logic [15:0]        con_drop
);

  localparam int AW = $clog2(CON_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {RUN, DRAIN, DONE, ABORT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idle_q;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW-1:0]   count;
  logic [7:0]      mem [CON_DEPTH];
  logic            finish_q, wdog_q;

  logic            empty, full, pop, push_req, push, drop;
  logic            fin_req, active, drained, wdog_hit;
  logic [2:0]      ret_inc;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (count == PW'(CON_DEPTH));
  assign pop      = !empty && con_ready;
  assign push_req = (state_q == RUN) && st_wen && (st_addr == CONSOLE_ADDR);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign fin_req  = (state_q == RUN) && st_wen && (st_addr == FINISH_ADDR);
  assign active   = (state_q == RUN) || (state_q == DRAIN);
  assign wdog_hit = (idle_q == IW'(WDOG_LIMIT));
  // No pushes happen outside RUN, so in DRAIN the FIFO is empty after this
  // edge if it is empty now or its last byte is popped this cycle.
  assign drained  = empty || ((count == PW'(1)) && pop);

  always_comb begin
    ret_inc = '0;
    for (int i = 0; i < NUM_RET; i++)
      ret_inc = ret_inc + 3'(ret_valid[i]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (fin_req)       state_d = DRAIN;
        else if (wdog_hit) state_d = ABORT;
      end
      DRAIN: begin
        if (drained) state_d = DONE;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      idle_q      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      finish_q    <= 1'b0;
      wdog_q      <= 1'b0;
      finish_code <= '0;
      cycle_cnt   <= '0;
      ret_cnt     <= '0;
      con_drop    <= '0;
    end else begin
      state_q  <= state_d;
      finish_q <= (state_d == DONE);
      wdog_q   <= (state_d == ABORT);
      if (fin_req) finish_code <= st_wdata;
      if (state_q == RUN) begin
        if (|ret_valid)    idle_q <= '0;
        else if (!wdog_hit) idle_q <= idle_q + IW'(1);
      end
      if (active) begin
        cycle_cnt <= cycle_cnt + 64'd1;
        ret_cnt   <= ret_cnt + 64'(ret_inc);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (drop && (con_drop != 16'hFFFF)) con_drop <= con_drop + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= st_wdata[7:0];
  end

  assign con_valid  = !empty;
  assign con_data   = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign finish     = finish_q;
  assign wdog_abort = wdog_q;

endmodule

// File: tb/tb_sim_host_ctrl.sv
module tb_sim_host_ctrl;

  localparam int          XLEN   = 32;
  localparam logic [31:0] FIN_A  = 32'h1000_0000;
  localparam logic [31:0] CON_A  = 32'h0020_0000;
  localparam int          DEPTH  = 8;
  localparam int          NRET   = 2;
  localparam int          LIMIT  = 1000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            st_wen = 1'b0;
  logic [31:0]     st_addr = '0;
  logic [31:0]     st_wdata = '0;
  logic [NRET-1:0] ret_valid = '0;
  logic            con_ready = 1'b0;
  logic            con_valid;
  logic [7:0]      con_data;
  logic            finish;
  logic [31:0]     finish_code;
  logic            wdog_abort;
  logic [63:0]     cycle_cnt;
  logic [63:0]     ret_cnt;
  logic [15:0]     con_drop;

  int errors = 0;
  int checks = 0;

  sim_host_ctrl #(
    .XLEN(XLEN), .FINISH_ADDR(FIN_A), .CONSOLE_ADDR(CON_A),
    .CON_DEPTH(DEPTH), .NUM_RET(NRET), .WDOG_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .st_wen(st_wen), .st_addr(st_addr),
    .st_wdata(st_wdata), .ret_valid(ret_valid), .con_valid(con_valid),
    .con_data(con_data), .con_ready(con_ready), .finish(finish),
    .finish_code(finish_code), .wdog_abort(wdog_abort),
    .cycle_cnt(cycle_cnt), .ret_cnt(ret_cnt), .con_drop(con_drop)
  );

  always #5 clk = ~clk;

  // Behavioural reference: run phase, a byte queue and plain counters.
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2, M_ABORT = 3;
  int          m_phase;
  int          m_idle;
  logic [63:0] m_cycles, m_rets;
  int          m_drop;
  logic [31:0] m_code;
  logic [7:0]  m_q[$];

  function automatic logic [7:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : 8'h00;
  endfunction

  task automatic model_step();
    int  pre_size;
    bit  pop, fin, push_req;
    if (rst) begin
      m_phase = M_RUN; m_idle = 0; m_cycles = 0; m_rets = 0;
      m_drop = 0; m_code = 0; m_q.delete();
      return;
    end
    pre_size = m_q.size();
    pop      = (pre_size > 0) && con_ready;
    fin      = (m_phase == M_RUN) && st_wen && (st_addr == FIN_A);
    push_req = (m_phase == M_RUN) && st_wen && (st_addr == CON_A);
    if (m_phase == M_RUN || m_phase == M_DRAIN) begin
      m_cycles = m_cycles + 1;
      m_rets   = m_rets + $countones(ret_valid);
    end
    if (pop) void'(m_q.pop_front());
    if (push_req) begin
      if (pre_size < DEPTH || pop) m_q.push_back(st_wdata[7:0]);
      else if (m_drop < 65535) m_drop++;
    end
    case (m_phase)
      M_RUN: begin
        if (fin) begin
          m_code = st_wdata;
          m_phase = M_DRAIN;
        end else if (m_idle == LIMIT) m_phase = M_ABORT;
        if (ret_valid != 0) m_idle = 0;
        else if (m_idle < LIMIT) m_idle++;
      end
      M_DRAIN: if (m_q.size() == 0) m_phase = M_DONE;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    st_wen = 1'b0; st_addr = '0; st_wdata = '0; ret_valid = '0; con_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    st_wen = 1'b1; st_addr = a; st_wdata = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({finish, wdog_abort, con_valid} !== 3'b000 || con_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got fin=%b wd=%b cv=%b cd=%h, want 0 0 0 00",
               finish, wdog_abort, con_valid, con_data);
    end
    checks++;
    if (cycle_cnt !== 64'd0 || ret_cnt !== 64'd0 || con_drop !== 16'd0 || finish_code !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got cyc=%0d ret=%0d drop=%0d code=%h, want all 0",
               cycle_cnt, ret_cnt, con_drop, finish_code);
    end
  endtask

  task automatic test_hello();
    do_reset();
    con_ready = 1'b1;
    ret_valid = 2'b01;
    store(CON_A, 32'h48);
    tick();
    store(CON_A, 32'h69);
    checks++;
    if (con_valid !== 1'b1 || con_data !== 8'h48) begin
      errors++;
      $display("FAIL hello_H: got cv=%b cd=%h, want 1 48", con_valid, con_data);
    end
    tick();
    st_wen = 1'b0;
    checks++;
    if (con_valid !== 1'b1 || con_data !== 8'h69) begin
      errors++;
      $display("FAIL hello_i: got cv=%b cd=%h, want 1 69", con_valid, con_data);
    end
    tick();
    store(FIN_A, 32'h0);
    tick();
    idle_inputs();
    checks++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL hello_drain: got finish=%b, want 0", finish);
    end
    tick();
    checks++;
    if (finish !== 1'b1 || finish_code !== 32'h0 || con_drop !== 16'd0 || wdog_abort !== 1'b0) begin
      errors++;
      $display("FAIL hello_done: got fin=%b code=%h drop=%0d wd=%b, want 1 0 0 0",
               finish, finish_code, con_drop, wdog_abort);
    end
  endtask

  task automatic test_fifo_full_drop();
    logic [7:0] got[$];
    bool_done: begin end
    do_reset();
    ret_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      store(CON_A, 32'h30 + i);
      tick();
    end
    st_wen = 1'b0;
    checks++;
    if (con_drop !== 16'd2 || con_valid !== 1'b1 || con_data !== 8'h30) begin
      errors++;
      $display("FAIL full_drop: got drop=%0d cv=%b cd=%h, want 2 1 30", con_drop, con_valid, con_data);
    end
    store(FIN_A, 32'h5);
    tick();
    st_wen = 1'b0;
    ret_valid = '0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (finish !== 1'b0 || con_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_hold: got fin=%b cv=%b, want 0 1", finish, con_valid);
    end
    con_ready = 1'b1;
    for (int i = 0; i < 20 && !finish; i++) begin
      if (con_valid) got.push_back(con_data);
      tick();
    end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL drain_count: got %0d bytes, want 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[i] !== 8'(8'h30 + i)) begin
          errors++;
          $display("FAIL drain_order[%0d]: got %h, want %h", i, got[i], 8'(8'h30 + i));
        end
      end
    end
    checks++;
    if (finish !== 1'b1 || finish_code !== 32'h5) begin
      errors++;
      $display("FAIL drain_done: got fin=%b code=%h, want 1 5 (timeout if 0)", finish, finish_code);
    end
  endtask

  task automatic test_watchdog();
    int n;
    logic [63:0] frozen;
    do_reset();
    n = 0;
    while (!wdog_abort && n < LIMIT + 50) begin
      tick();
      n++;
    end
    checks++;
    if (n != LIMIT + 1 || wdog_abort !== 1'b1) begin
      errors++;
      $display("FAIL wdog_latency: got abort after %0d cycles (abort=%b), want %0d",
               n, wdog_abort, LIMIT + 1);
    end
    frozen = cycle_cnt;
    checks++;
    if (frozen !== 64'(LIMIT + 1)) begin
      errors++;
      $display("FAIL wdog_cycles: got %0d, want %0d", frozen, LIMIT + 1);
    end
    ret_valid = 2'b11;
    store(FIN_A, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    idle_inputs();
    checks++;
    if (cycle_cnt !== frozen || wdog_abort !== 1'b1 || finish !== 1'b0) begin
      errors++;
      $display("FAIL wdog_frozen: got cyc=%0d wd=%b fin=%b, want %0d 1 0",
               cycle_cnt, wdog_abort, finish, frozen);
    end
  endtask

  task automatic test_retire();
    do_reset();
    ret_valid = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    ret_valid = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    ret_valid = 2'b00;
    checks++;
    if (ret_cnt !== 64'd13 || wdog_abort !== 1'b0) begin
      errors++;
      $display("FAIL retire_cnt: got ret=%0d wd=%b, want 13 0", ret_cnt, wdog_abort);
    end
  endtask

  task automatic test_finish_vs_wdog();
    do_reset();
    for (int i = 0; i < LIMIT; i++) tick();
    store(FIN_A, 32'hDEAD_BEEF);
    tick();
    st_wen = 1'b0;
    checks++;
    if (finish_code !== 32'hDEAD_BEEF || wdog_abort !== 1'b0) begin
      errors++;
      $display("FAIL fin_vs_wdog_edge: got code=%h wd=%b, want deadbeef 0", finish_code, wdog_abort);
    end
    tick();
    checks++;
    if (finish !== 1'b1 || wdog_abort !== 1'b0) begin
      errors++;
      $display("FAIL fin_vs_wdog_done: got fin=%b wd=%b, want 1 0", finish, wdog_abort);
    end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    ret_valid = 2'b10;
    for (int i = 0; i < 8; i++) begin
      store(CON_A, 32'h50 + i);
      tick();
    end
    store(CON_A, 32'h58);
    con_ready = 1'b1;
    tick();
    con_ready = 1'b0;
    checks++;
    if (con_drop !== 16'd0 || con_data !== 8'h51) begin
      errors++;
      $display("FAIL pop_push_accept: got drop=%0d cd=%h, want 0 51", con_drop, con_data);
    end
    store(CON_A, 32'h59);
    tick();
    st_wen = 1'b0;
    checks++;
    if (con_drop !== 16'd1) begin
      errors++;
      $display("FAIL pop_push_full: got drop=%0d, want 1 (occupancy must stay 8)", con_drop);
    end
    con_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (con_valid !== 1'b0 || con_data !== 8'h00 || con_drop !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_drain: got cv=%b cd=%h drop=%0d, want 0 00 0", con_valid, con_data, con_drop);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int stuck;
    do_reset();
    stuck = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      st_wen   = (r < 40);
      st_addr  = (r < 25) ? CON_A : ((r < 27) ? FIN_A : $urandom());
      st_wdata = $urandom();
      ret_valid = ($urandom_range(0, 3) == 0) ? '0 : NRET'($urandom());
      con_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 499) == 0) || (stuck > 20);
      tick();
      stuck = (m_phase == M_DONE || m_phase == M_ABORT) ? stuck + 1 : 0;
      checks++;
      if (finish !== (m_phase == M_DONE) || wdog_abort !== (m_phase == M_ABORT)) begin
        errors++;
        $display("FAIL rnd_state c=%0d: got fin=%b wd=%b, want phase %0d", c, finish, wdog_abort, m_phase);
      end
      checks++;
      if (con_valid !== (m_q.size() > 0) || con_data !== m_head()) begin
        errors++;
        $display("FAIL rnd_con c=%0d: got cv=%b cd=%h, want %b %h", c, con_valid, con_data,
                 m_q.size() > 0, m_head());
      end
      checks++;
      if (cycle_cnt !== m_cycles || ret_cnt !== m_rets) begin
        errors++;
        $display("FAIL rnd_cnt c=%0d: got cyc=%0d ret=%0d, want %0d %0d", c, cycle_cnt, ret_cnt,
                 m_cycles, m_rets);
      end
      checks++;
      if (con_drop !== 16'(m_drop) || finish_code !== m_code) begin
        errors++;
        $display("FAIL rnd_drop_code c=%0d: got drop=%0d code=%h, want %0d %h", c, con_drop,
                 finish_code, m_drop, m_code);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hello();
    test_fifo_full_drop();
    test_watchdog();
    test_retire();
    test_finish_vs_wdog();
    test_full_pop_push();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
